// File: rtl/codec_init_sequencer_if.sv
// I2C controller request/response bus between the codec init sequencer (master)
// and the I2C controller (slave).
interface codec_init_sequencer_if;
  logic        i2c_start;
  logic        i2c_rnw;
  logic [15:0] i2c_address;
  logic [7:0]  i2c_wdata;
  logic        i2c_done;
  logic [7:0]  i2c_rdata;

  modport master (
    output i2c_start, i2c_rnw, i2c_address, i2c_wdata,
    input  i2c_done, i2c_rdata
  );

  modport slave (
    input  i2c_start, i2c_rnw, i2c_address, i2c_wdata,
    output i2c_done, i2c_rdata
  );
endinterface

// File: rtl/codec_init_sequencer.sv
// ADAU1761 power-up sequencer: walks a register table, writes each entry over I2C,
// optionally reads it back, retries failures and reports done or error.
module codec_init_sequencer #(
  parameter int unsigned C_NUM_REGS     = 16,
  parameter logic [23:0] C_POWERUP_WAIT = 24'd1000,
  parameter logic [23:0] C_TIMEOUT      = 24'd100000,
  parameter logic [2:0]  C_MAX_RETRY    = 3'd3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          go,
  output logic [7:0]                    tbl_index,
  input  logic [24:0]                   tbl_entry,
  codec_init_sequencer_if.master        i2c,
  output logic                          init_done,
  output logic                          init_error,
  output logic [7:0]                    err_index
);

  typedef enum logic [3:0] {
    S_WAIT,
    S_FETCH,
    S_WRITE,
    S_WRITE_WAIT,
    S_READ,
    S_READ_WAIT,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [7:0] LAST_INDEX = 8'(C_NUM_REGS - 1);

  state_t      state;
  state_t      next_state;
  logic [23:0] wait_cnt;
  logic [23:0] tmo_cnt;
  logic [2:0]  retry_cnt;
  logic [2:0]  retry_next;
  logic        verify_q;
  logic        tmo_hit;
  logic        fail;

  assign tmo_hit    = (tmo_cnt == C_TIMEOUT - 24'd1);
  assign retry_next = retry_cnt + 3'd1;

  // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_WAIT;
    else      state <= next_state;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    next_state = state;
    fail       = 1'b0;
    case (state)
      S_WAIT:       if (wait_cnt == C_POWERUP_WAIT - 24'd1) next_state = S_FETCH;
      S_FETCH:      next_state = S_WRITE;
      S_WRITE:      next_state = S_WRITE_WAIT;
      S_WRITE_WAIT: begin
        // A done pulse beats a simultaneous timeout.
        if (i2c.i2c_done)  next_state = verify_q ? S_READ : S_NEXT;
        else if (tmo_hit)  fail = 1'b1;
      end
      S_READ:       next_state = S_READ_WAIT;
      S_READ_WAIT: begin
        if (i2c.i2c_done) begin
          if (i2c.i2c_rdata == i2c.i2c_wdata) next_state = S_NEXT;
          else                                 fail = 1'b1;
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end
      S_NEXT:       next_state = (tbl_index == LAST_INDEX) ? S_DONE : S_FETCH;
      S_DONE,
      S_ERROR:      if (go) next_state = S_FETCH;
      default:      next_state = S_WAIT;
    endcase

    // Any failure restarts the entry from its write, or gives up once retries run out.
    if (fail) next_state = (retry_next == C_MAX_RETRY) ? S_ERROR : S_WRITE;
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt        <= '0;
      tmo_cnt         <= '0;
      retry_cnt       <= '0;
      verify_q        <= 1'b0;
      tbl_index       <= '0;
      i2c.i2c_start   <= 1'b0;
      i2c.i2c_rnw     <= 1'b0;
      i2c.i2c_address <= '0;
      i2c.i2c_wdata   <= '0;
      init_done       <= 1'b0;
      init_error      <= 1'b0;
      err_index       <= '0;
    end else begin
      // Request strobes are registered so they are high exactly while in S_WRITE/S_READ.
      i2c.i2c_start <= (next_state == S_WRITE) || (next_state == S_READ);
      if (next_state == S_WRITE) i2c.i2c_rnw <= 1'b0;
      if (next_state == S_READ)  i2c.i2c_rnw <= 1'b1;

      case (state)
        S_WAIT: wait_cnt <= wait_cnt + 24'd1;
        S_FETCH: begin
          verify_q        <= tbl_entry[24];
          i2c.i2c_address <= tbl_entry[23:8];
          i2c.i2c_wdata   <= tbl_entry[7:0];
          retry_cnt       <= '0;
        end
        S_WRITE,
        S_READ:       tmo_cnt <= '0;
        S_WRITE_WAIT,
        S_READ_WAIT:  tmo_cnt <= tmo_cnt + 24'd1;
        S_NEXT: begin
          if (next_state == S_FETCH) tbl_index <= tbl_index + 8'd1;
          else                       init_done <= 1'b1;
        end
        S_DONE,
        S_ERROR: begin
          if (go) begin
            init_done  <= 1'b0;
            init_error <= 1'b0;
            tbl_index  <= '0;
          end
        end
        default: ;
      endcase

      if (fail) begin
        retry_cnt <= retry_next;
        if (next_state == S_ERROR) begin
          init_error <= 1'b1;
          err_index  <= tbl_index;
        end
      end
    end
  end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Directed bench for codec_init_sequencer: table ROM, 5-cycle I2C controller model,
// start-request log compared against hand-computed cycle/address/data expectations.
module tb_codec_init_sequencer;

  typedef enum {M_ECHO, M_ZERO, M_SILENT} mode_t;

  typedef struct {
    int          cyc;
    logic        rnw;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } start_t;

  typedef struct {
    logic [24:0] entry;
    int          exp_cyc;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        go;
  logic [7:0]  tbl_index;
  logic [24:0] tbl_entry;
  logic        init_done;
  logic        init_error;
  logic [7:0]  err_index;

  logic [24:0] rom [4];
  mode_t       mode;
  int          cyc;
  int          done_cyc;
  int          error_cyc;
  int          checks;
  int          failures;
  int          base;
  int unsigned resp_cnt;
  logic [7:0]  last_wdata;
  start_t      log_q [$];
  start_t      exp_q [$];
  vec_t        vecs [3];

  codec_init_sequencer_if bus ();

  codec_init_sequencer #(
    .C_NUM_REGS     (3),
    .C_POWERUP_WAIT (24'd4),
    .C_TIMEOUT      (24'd10),
    .C_MAX_RETRY    (3'd3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .tbl_index  (tbl_index),
    .tbl_entry  (tbl_entry),
    .i2c        (bus),
    .init_done  (init_done),
    .init_error (init_error),
    .err_index  (err_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tbl_entry = rom[tbl_index[1:0]];

  // Cycle k is the period sampled by the k-th rising edge with rst high.
  always @(posedge clk) begin
    if (rst) cyc = cyc + 1;
    else     cyc = 0;
  end

  // Controller model: answers 5 cycles after each start unless silent.
  always @(negedge clk) begin
    bus.i2c_done = 1'b0;
    if (resp_cnt != 0) begin
      resp_cnt = resp_cnt - 1;
      if (resp_cnt == 0) begin
        bus.i2c_done  = 1'b1;
        bus.i2c_rdata = (mode == M_ECHO) ? last_wdata : 8'h00;
      end
    end
    if (bus.i2c_start && mode != M_SILENT) begin
      resp_cnt = 5;
      if (!bus.i2c_rnw) last_wdata = bus.i2c_wdata;
    end
  end

  always @(negedge clk) begin
    if (bus.i2c_start)
      log_q.push_back('{cyc: cyc, rnw: bus.i2c_rnw, addr: bus.i2c_address, wdata: bus.i2c_wdata});
    if (init_done && done_cyc < 0)   done_cyc = cyc;
    if (init_error && error_cyc < 0) error_cyc = cyc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    log_q.delete();
    exp_q.delete();
    done_cyc  = -1;
    error_cyc = -1;
  endtask

  task automatic expect_start(input int c, input logic rnw, input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back('{cyc: c, rnw: rnw, addr: a, wdata: d});
  endtask

  task automatic check_log(input string tag, input int b);
    check({tag, " start count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size()) begin
        check($sformatf("%s start%0d cycle", tag, i), log_q[i].cyc, b + exp_q[i].cyc);
        check($sformatf("%s start%0d rnw", tag, i), 32'(log_q[i].rnw), 32'(exp_q[i].rnw));
        check($sformatf("%s start%0d addr", tag, i), 32'(log_q[i].addr), 32'(exp_q[i].addr));
        check($sformatf("%s start%0d wdata", tag, i), 32'(log_q[i].wdata), 32'(exp_q[i].wdata));
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " tbl_index"},   32'(tbl_index), 32'h0);
    check({tag, " i2c_start"},   32'(bus.i2c_start), 32'h0);
    check({tag, " i2c_rnw"},     32'(bus.i2c_rnw), 32'h0);
    check({tag, " i2c_address"}, 32'(bus.i2c_address), 32'h0);
    check({tag, " i2c_wdata"},   32'(bus.i2c_wdata), 32'h0);
    check({tag, " init_done"},   32'(init_done), 32'h0);
    check({tag, " init_error"},  32'(init_error), 32'h0);
    check({tag, " err_index"},   32'(err_index), 32'h0);
  endtask

  // Pulses go for one cycle; returns with the clearing edge already taken.
  task automatic pulse_go(output int b);
    go = 1'b1;
    b  = cyc;
    @(negedge clk);
    go = 1'b0;
    clear_log();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    resp_cnt   = 0;
    last_wdata = 8'h00;
    rst        = 1'b0;
    go         = 1'b0;
    mode       = M_ECHO;

    vecs[0] = '{entry: {1'b0, 16'h4000, 8'h01}, exp_cyc: 5,  exp_addr: 16'h4000, exp_wdata: 8'h01};
    vecs[1] = '{entry: {1'b0, 16'h4002, 8'h02}, exp_cyc: 13, exp_addr: 16'h4002, exp_wdata: 8'h02};
    vecs[2] = '{entry: {1'b0, 16'h4015, 8'h03}, exp_cyc: 21, exp_addr: 16'h4015, exp_wdata: 8'h03};
    for (int i = 0; i < 3; i++) rom[i] = vecs[i].entry;
    rom[3] = '0;

    // Power-up: reset values, then three plain writes in table order.
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    clear_log();
    rst = 1'b1;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 3; i++) expect_start(vecs[i].exp_cyc, 1'b0, vecs[i].exp_addr, vecs[i].exp_wdata);
    check_log("plain", 0);
    check("plain init_done cycle", done_cyc, 28);
    check("plain init_error", 32'(init_error), 32'h0);

    // Verified entry that reads back correctly.
    rom[1] = {1'b1, 16'h4008, 8'h5A};
    mode   = M_ECHO;
    pulse_go(base);
    check("go clears init_done", 32'(init_done), 32'h0);
    check("go clears tbl_index", 32'(tbl_index), 32'h0);
    repeat (40) @(negedge clk);
    expect_start(2,  1'b0, 16'h4000, 8'h01);
    expect_start(10, 1'b0, 16'h4008, 8'h5A);
    expect_start(16, 1'b1, 16'h4008, 8'h5A);
    expect_start(24, 1'b0, 16'h4015, 8'h03);
    check_log("verify_ok", base);
    check("verify_ok init_done cycle", done_cyc, base + 31);

    // Read-back always mismatches: three write/read pairs, then error on entry 1.
    mode = M_ZERO;
    pulse_go(base);
    repeat (80) @(negedge clk);
    expect_start(2, 1'b0, 16'h4000, 8'h01);
    for (int i = 0; i < 3; i++) begin
      expect_start(10 + 12 * i, 1'b0, 16'h4008, 8'h5A);
      expect_start(16 + 12 * i, 1'b1, 16'h4008, 8'h5A);
    end
    check_log("mismatch", base);
    check("mismatch error cycle", error_cyc, base + 46);
    check("mismatch init_error", 32'(init_error), 32'h1);
    check("mismatch err_index", 32'(err_index), 32'h1);
    check("mismatch init_done", 32'(init_done), 32'h0);

    // Controller never answers: timeouts 11 cycles apart; a go in S_WRITE_WAIT is ignored.
    mode = M_SILENT;
    pulse_go(base);
    check("go clears init_error", 32'(init_error), 32'h0);
    check("go clears tbl_index err", 32'(tbl_index), 32'h0);
    while (cyc < base + 5) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (50) @(negedge clk);
    for (int i = 0; i < 3; i++) expect_start(2 + 11 * i, 1'b0, 16'h4000, 8'h01);
    check_log("timeout", base);
    check("timeout error cycle", error_cyc, base + 35);
    check("timeout err_index", 32'(err_index), 32'h0);

    // Reset pulse during S_READ_WAIT; the late done must not disturb the restart.
    mode = M_ECHO;
    pulse_go(base);
    while (cyc < base + 18) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    clear_log();
    rst = 1'b1;
    repeat (45) @(negedge clk);
    expect_start(5,  1'b0, 16'h4000, 8'h01);
    expect_start(13, 1'b0, 16'h4008, 8'h5A);
    expect_start(19, 1'b1, 16'h4008, 8'h5A);
    expect_start(27, 1'b0, 16'h4015, 8'h03);
    check_log("restart", 0);
    check("restart init_done cycle", done_cyc, 34);
    check("restart init_error", 32'(init_error), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/codec_init_sequencer.md
# codec_init_sequencer

Power-up configuration sequencer for the ADAU1761 codec. After reset it walks a synchronous register table of {verify, 16-bit register address, 8-bit data} entries. For each entry it issues one I2C write through the I2C controller, and optionally reads the register back to verify it. It retries failed transactions and then reports done or error. It sits directly upstream of the I2C controller and drives that controller's `start`/`rnw`/`address`/`wdata` inputs.

## Interface
Parameters:
- `C_NUM_REGS`, 16: number of table entries (1..256).
- `C_POWERUP_WAIT`, 24'd1000: cycles to wait after reset before the first fetch (≥1).
- `C_TIMEOUT`, 24'd100000: cycles allowed between `i2c_start` and `i2c_done` (≥2).
- `C_MAX_RETRY`, 3'd3: attempts per entry before the block flags an error (≥1).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-low reset.
- `go`  in  1  restart pulse; honoured only in S_DONE or S_ERROR.
- `tbl_index`  out  8  table address, registered.
- `tbl_entry`  in  25  {verify[24], addr[23:8], data[7:0]}; valid one cycle after `tbl_index` changes.
- `i2c_start`  out  1  one-cycle transaction request.
- `i2c_rnw`  out  1  1 = read, 0 = write; held stable for the whole transaction.
- `i2c_address`  out  16  codec register address; held.
- `i2c_wdata`  out  8  write data; held.
- `i2c_done`  in  1  one-cycle pulse when the controller finishes a transaction.
- `i2c_rdata`  in  8  read data; valid in the `i2c_done` cycle.
- `init_done`  out  1  level: all entries written and verified.
- `init_error`  out  1  level: an entry exhausted its retries.
- `err_index`  out  8  index of the failed entry; valid while `init_error`=1.

## Operation
- States: S_WAIT, S_FETCH, S_WRITE, S_WRITE_WAIT, S_READ, S_READ_WAIT, S_NEXT, S_DONE, S_ERROR.
- S_WAIT: counts `C_POWERUP_WAIT` cycles, then goes to S_FETCH.
- S_FETCH: one cycle (ROM latency). Then the block captures `tbl_entry` into its address, data and verify registers, clears the retry count, and goes to S_WRITE.
- S_WRITE: drives `i2c_start`=1 and `i2c_rnw`=0 for one cycle, clears the timeout counter, then goes to S_WRITE_WAIT.
- S_WRITE_WAIT:
  - On `i2c_done`: goes to S_READ if verify=1, else S_NEXT.
  - On timeout: counts as a failure.
- S_READ: drives `i2c_start`=1 and `i2c_rnw`=1 for one cycle, then goes to S_READ_WAIT.
- S_READ_WAIT:
  - On `i2c_done` with `i2c_rdata`==data: goes to S_NEXT.
  - On a mismatch or timeout: counts as a failure.
- Failure handling:
  - The retry count increments.
  - If the new count equals `C_MAX_RETRY`: goes to S_ERROR and loads `err_index`=`tbl_index`.
  - Otherwise: goes to S_WRITE. A retry always re-writes; it never re-reads alone.
- S_NEXT:
  - If `tbl_index`==`C_NUM_REGS`-1: goes to S_DONE.
  - Otherwise: increments `tbl_index` and goes to S_FETCH.
- S_DONE and S_ERROR are sticky. In either state, `go`=1 clears `init_done`, `init_error` and `tbl_index`, then goes to S_FETCH with no power-up wait. `go` is ignored in every other state.
- `i2c_done` in any state other than S_WRITE_WAIT or S_READ_WAIT is ignored.
- If `i2c_done` and the timeout arrive in the same cycle, `i2c_done` wins.
- Every registered output is stable except in the cycles where this spec changes it.

## Timing
- Reset values: `tbl_index`=0, `i2c_start`=0, `i2c_rnw`=0, `i2c_address`=0, `i2c_wdata`=0, `init_done`=0, `init_error`=0, `err_index`=0. State after reset is S_WAIT with the counter at 0.
- Cycle numbering: cycle 0 is the first rising edge with `rst`=1.
  - S_WAIT occupies cycles 0..`C_POWERUP_WAIT`-1.
  - S_FETCH is at cycle `C_POWERUP_WAIT`.
  - The first `i2c_start` is high during cycle `C_POWERUP_WAIT`+1.
- `i2c_address`, `i2c_wdata` and `i2c_rnw` are valid in the same cycle as `i2c_start` and hold until the next `i2c_start`.
- Timeout point: the timeout fires when the counter reaches `C_TIMEOUT`-1 with no `i2c_done`. That is cycle `C_TIMEOUT` after the `i2c_start` cycle.
- Entry-to-entry latency (no verify): from the `i2c_done` cycle, S_NEXT takes 1 cycle and S_FETCH takes 1 cycle. The next `i2c_start` therefore comes 3 cycles after `i2c_done`.
- `init_done` rises 2 cycles after the final `i2c_done`: S_NEXT, then registered into S_DONE.
- Asserting `rst` low mid-transaction: the block returns to reset values on the next edge. A pending `i2c_done` from the aborted transaction is ignored because the block is in S_WAIT.
- Counter widths: the wait and timeout counters are 24 bits; the retry counter is 3 bits. No wrap-around is reachable within the legal parameter ranges.

## Test plan
- `C_POWERUP_WAIT`=4, `C_NUM_REGS`=3, no verify, controller model answers `i2c_done` 5 cycles after each start -> first `i2c_start` at cycle 5; addresses 0x4000, 0x4002, 0x4015 issued in table order; `init_done`=1 2 cycles after the third done.
- Entry {verify=1, 0x4008, 0x5A}, model returns 0x5A -> one write then one read with `i2c_rnw`=1; the sequence advances.
- Same entry, model returns 0x00 every time, `C_MAX_RETRY`=3 -> exactly 3 write/read pairs; then `init_error`=1, `err_index`=entry index, `init_done`=0; no further starts.
- Model never answers, `C_TIMEOUT`=10 -> starts spaced 11 cycles apart; error after `C_MAX_RETRY` attempts.
- From S_ERROR pulse `go` -> `init_error` clears; `tbl_index`=0; `i2c_start` 2 cycles later with no power-up wait. A `go` pulse issued during S_WRITE_WAIT is ignored.
- `rst` low for 1 cycle during S_READ_WAIT -> all outputs at reset values; a late `i2c_done` is ignored; the full sequence restarts after `C_POWERUP_WAIT`.
